// File: rtl/btc_nonce_result_fifo_if.sv
// Bus between the nonce result FIFO and its neighbours: the core-side result
// inputs, the register-block pop/clear controls and the status/readout outputs.
interface btc_nonce_result_fifo_if #(
  parameter int DEPTH   = 4,
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               clear;
  logic               found_flag;
  logic [NONCE_W-1:0] nonce_out;
  logic               core_done;
  logic               pop;
  logic [NONCE_W-1:0] head_nonce;
  logic [CW-1:0]      count;
  logic               empty;
  logic               full;
  logic               overflow;
  logic               done_seen;
  logic [CNT_W-1:0]   hits;
  logic               irq;

  modport master (
    output clear, found_flag, nonce_out, core_done, pop,
    input  head_nonce, count, empty, full, overflow, done_seen, hits, irq
  );

  modport slave (
    input  clear, found_flag, nonce_out, core_done, pop,
    output head_nonce, count, empty, full, overflow, done_seen, hits, irq
  );
endinterface

// File: rtl/btc_nonce_result_fifo.sv
// Queues winning nonces from the mining core for the register block, with
// sticky done/overflow status, a saturating hit counter and a pending irq.
module btc_nonce_result_fifo #(
  parameter int DEPTH   = 4,
  parameter int NONCE_W = 32,
  parameter int CNT_W   = 16
) (
  input logic                 clk,
  input logic                 arst_n_a,
  btc_nonce_result_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][NONCE_W-1:0] mem;
  logic [PW-1:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [NONCE_W-1:0] head_q, head_nxt;
  logic [CNT_W-1:0]   hits_q;
  logic               found_q, done_q;
  logic               ovf_q, ovf_nxt, done_seen_q, irq_q;
  logic               push_req, done_rise, do_push, do_pop, is_empty, is_full;

  assign is_empty  = (cnt == '0);
  assign is_full   = (cnt == CW'(DEPTH));
  assign push_req  = bus.found_flag & ~found_q;
  assign done_rise = bus.core_done & ~done_q;
  assign do_pop    = bus.pop & ~is_empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO survives.
  assign do_push   = push_req & (~is_full | do_pop);

  always_comb begin
    rd_ptr_nxt = rd_ptr + PW'(do_pop);
    cnt_nxt    = cnt + CW'(do_push) - CW'(do_pop);
    ovf_nxt    = ovf_q | (push_req & is_full & ~do_pop);
    head_nxt   = '0;
    // Forward the incoming nonce when it becomes the head (empty or last-entry pop).
    if (cnt_nxt != '0)
      head_nxt = (do_push && (wr_ptr == rd_ptr_nxt)) ? bus.nonce_out : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk or negedge arst_n_a) begin
    if (!arst_n_a) begin
      mem         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      head_q      <= '0;
      hits_q      <= '0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_seen_q <= 1'b0;
      irq_q       <= 1'b0;
    end else if (bus.clear) begin
      mem         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      head_q      <= '0;
      hits_q      <= '0;
      // Track current levels so a level already high is not seen as a new edge.
      found_q     <= bus.found_flag;
      done_q      <= bus.core_done;
      ovf_q       <= 1'b0;
      done_seen_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      found_q <= bus.found_flag;
      done_q  <= bus.core_done;
      if (do_push) begin
        mem[wr_ptr] <= bus.nonce_out;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      head_q <= head_nxt;
      ovf_q  <= ovf_nxt;
      irq_q  <= (cnt_nxt != '0) | ovf_nxt;
      if (done_rise)
        done_seen_q <= 1'b1;
      if (push_req && (hits_q != '1))
        hits_q <= hits_q + CNT_W'(1);
    end
  end

  assign bus.head_nonce = head_q;
  assign bus.count      = cnt;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = ovf_q;
  assign bus.done_seen  = done_seen_q;
  assign bus.hits       = hits_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_btc_nonce_result_fifo.sv
// Directed and random checks of the nonce result FIFO against a queue model.
module tb_btc_nonce_result_fifo;
  localparam int DEPTH   = 4;
  localparam int NONCE_W = 32;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic arst_n_a = 1'b0;
  always #5 clk = ~clk;

  btc_nonce_result_fifo_if #(.DEPTH(DEPTH), .NONCE_W(NONCE_W), .CNT_W(CNT_W)) bif ();

  btc_nonce_result_fifo #(.DEPTH(DEPTH), .NONCE_W(NONCE_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .arst_n_a (arst_n_a),
    .bus      (bif)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending nonces plus sticky flags.
  logic [NONCE_W-1:0] mq[$];
  bit m_ovf, m_ds, m_pf, m_pd;
  int m_hits;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NONCE_W-1:0] eh;
    eh = (mq.size() != 0) ? mq[0] : '0;
    chk("head_nonce", 64'(bif.head_nonce), 64'(eh));
    chk("count", 64'(bif.count), 64'(mq.size()));
    chk("empty", 64'(bif.empty), 64'(mq.size() == 0));
    chk("full", 64'(bif.full), 64'(mq.size() == DEPTH));
    chk("overflow", 64'(bif.overflow), 64'(m_ovf));
    chk("done_seen", 64'(bif.done_seen), 64'(m_ds));
    chk("hits", 64'(bif.hits), 64'(m_hits));
    chk("irq", 64'(bif.irq), 64'((mq.size() != 0) || m_ovf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_ds = 0; m_pf = 0; m_pd = 0; m_hits = 0;
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 ns later.
  task automatic step(bit f, logic [NONCE_W-1:0] n, bit d, bit p, bit c);
    bit pr, dr;
    bif.found_flag = f; bif.nonce_out = n; bif.core_done = d;
    bif.pop = p; bif.clear = c;
    @(posedge clk);
    if (c) begin
      mq.delete();
      m_ovf = 0; m_ds = 0; m_hits = 0;
    end else begin
      pr = f && !m_pf;
      dr = d && !m_pd;
      if (pr && m_hits < (1 << CNT_W) - 1) m_hits++;
      if (p && mq.size() > 0) begin
        void'(mq.pop_front());
        if (pr) mq.push_back(n);
      end else if (pr) begin
        if (mq.size() == DEPTH) m_ovf = 1;
        else mq.push_back(n);
      end
      if (dr) m_ds = 1;
    end
    m_pf = f; m_pd = d;
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic push(logic [NONCE_W-1:0] n);
    step(1, n, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bif.found_flag = 0; bif.nonce_out = '0; bif.core_done = 0;
    bif.pop = 0; bif.clear = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    arst_n_a = 1'b1;

    // First capture then pop
    step(1, 32'hDEADBEEF, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Held level counts once
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 32'h1234_0000 + i, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Overflow with five pushes
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) push(i);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Push and pop together while full
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) push(i);
    step(1, 9, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

    // Wrap-around
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 100 + i, 0, 0, 0);
      step(0, 0, 0, 1, 0);
    end

    // Clear beats push and done edge
    step(0, 0, 0, 0, 0);
    push(55);
    step(1, 77, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 49) == 0));

    // Asynchronous reset mid-stream
    step(0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) push(32'hA000_0000 + i);
    #2;
    arst_n_a = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    arst_n_a = 1'b1;
    push(32'hCAFEF00D);
    step(0, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
